// File: rtl/l2_cache_pkg.sv
// Shared types, geometry constants and address-split helpers for the L2 cache.
package l2_cache_pkg;

  localparam int unsigned L2_LINES    = 1024;
  localparam int unsigned INDEX_W     = 10;
  localparam int unsigned OFFSET_W    = 4;
  localparam int unsigned TAG_W       = 32 - INDEX_W - OFFSET_W;
  localparam int unsigned BLOCK_WORDS = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMemReq,
    StMemFill,
    StResp,
    StWrMem
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[31:32-TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
    return addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  endfunction

  function automatic logic [1:0] addr_word(input logic [31:0] addr);
    return addr[3:2];
  endfunction

endpackage

// File: rtl/l2_cache_if.sv
// L1-side request/response and memory-side bus signals of the L2 cache.
interface l2_cache_if;

  logic        l1_req_valid;
  logic        l1_req_ready;
  logic [31:0] l1_req_addr;
  logic        l1_req_write;
  logic [31:0] l1_req_wdata;
  logic        l2_resp_valid;
  logic [31:0] l2_resp_data;
  logic [1:0]  l2_resp_word;
  logic        l2_resp_last;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;

  // The cache itself.
  modport slave (
    input  l1_req_valid, l1_req_addr, l1_req_write, l1_req_wdata,
    input  mem_req_ready, mem_rdata_valid, mem_rdata,
    output l1_req_ready, l2_resp_valid, l2_resp_data, l2_resp_word, l2_resp_last,
    output mem_req_valid, mem_req_write, mem_addr, mem_wdata
  );

  // The surrounding L1 and memory controller.
  modport master (
    output l1_req_valid, l1_req_addr, l1_req_write, l1_req_wdata,
    output mem_req_ready, mem_rdata_valid, mem_rdata,
    input  l1_req_ready, l2_resp_valid, l2_resp_data, l2_resp_word, l2_resp_last,
    input  mem_req_valid, mem_req_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/l2_tag_store.sv
// Valid bits and tags of the direct-mapped L2, with a lookup port and a fill port.
module l2_tag_store
  import l2_cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] lookup_index,
  input  logic [TAG_W-1:0]   lookup_tag,
  output logic               hit,
  input  logic               fill_en,
  input  logic [INDEX_W-1:0] fill_index,
  input  logic [TAG_W-1:0]   fill_tag
);

  logic [L2_LINES-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q [L2_LINES];

  // Valid bits: cleared by reset, set only once a line is completely filled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_index] <= 1'b1;
    end
  end

  // Tag array: no reset, it is qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_index] <= fill_tag;
    end
  end

  assign hit = valid_q[lookup_index] && (tag_q[lookup_index] == lookup_tag);

endmodule

// File: rtl/l2_cache.sv
// Direct-mapped write-through no-write-allocate L2: data array plus control FSM.
module l2_cache
  import l2_cache_pkg::*;
(
  input logic     clk,
  input logic     rst,
  l2_cache_if.slave bus
);

  state_e       state_q;
  logic [31:0]  addr_q;
  logic [31:0]  wdata_q;
  logic         write_q;
  logic [1:0]   cnt_q;
  logic         ready_q;
  logic         resp_valid_q;
  logic [31:0]  resp_data_q;
  logic [1:0]   resp_word_q;
  logic         resp_last_q;
  logic         mreq_valid_q;
  logic         mreq_write_q;
  logic [31:0]  maddr_q;
  logic [31:0]  mwdata_q;

  logic [31:0]  data_q [L2_LINES*BLOCK_WORDS];

  logic [INDEX_W-1:0] idx;
  logic               hit;
  logic               fill_en;
  logic [1:0]         rd_word;
  logic [31:0]        rd_data;

  assign idx     = addr_index(addr_q);
  assign fill_en = (state_q == StMemFill) && bus.mem_rdata_valid && (cnt_q == 2'd3);
  // First beat is read while entering RESP; later beats read the word after the current one.
  assign rd_word = (state_q == StResp) ? resp_word_q + 2'd1 : 2'd0;
  assign rd_data = data_q[{idx, rd_word}];

  l2_tag_store u_tag_store (
    .clk          (clk),
    .rst          (rst),
    .lookup_index (idx),
    .lookup_tag   (addr_tag(addr_q)),
    .hit          (hit),
    .fill_en      (fill_en),
    .fill_index   (idx),
    .fill_tag     (addr_tag(addr_q))
  );

  // Data array: refill beats and write-hit word updates; not reset.
  always_ff @(posedge clk) begin
    if (state_q == StMemFill && bus.mem_rdata_valid) begin
      data_q[{idx, cnt_q}] <= bus.mem_rdata;
    end else if (state_q == StLookup && write_q && hit) begin
      data_q[{idx, addr_word(addr_q)}] <= wdata_q;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_word_q  <= '0;
      resp_last_q  <= 1'b0;
      mreq_valid_q <= 1'b0;
      mreq_write_q <= 1'b0;
      maddr_q      <= '0;
      mwdata_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.l1_req_valid && ready_q) begin
            ready_q <= 1'b0;
            addr_q  <= bus.l1_req_addr;
            write_q <= bus.l1_req_write;
            wdata_q <= bus.l1_req_wdata;
            state_q <= StLookup;
          end else begin
            ready_q <= 1'b1;
          end
        end
        StLookup: begin
          if (write_q) begin
            mreq_valid_q <= 1'b1;
            mreq_write_q <= 1'b1;
            maddr_q      <= {addr_q[31:2], 2'b00};
            mwdata_q     <= wdata_q;
            state_q      <= StWrMem;
          end else if (hit) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= rd_data;
            resp_word_q  <= 2'd0;
            resp_last_q  <= 1'b0;
            state_q      <= StResp;
          end else begin
            mreq_valid_q <= 1'b1;
            mreq_write_q <= 1'b0;
            maddr_q      <= {addr_q[31:4], 4'h0};
            state_q      <= StMemReq;
          end
        end
        StMemReq: begin
          if (bus.mem_req_ready) begin
            mreq_valid_q <= 1'b0;
            cnt_q        <= 2'd0;
            state_q      <= StMemFill;
          end
        end
        StMemFill: begin
          if (bus.mem_rdata_valid) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              resp_valid_q <= 1'b1;
              resp_data_q  <= rd_data;
              resp_word_q  <= 2'd0;
              resp_last_q  <= 1'b0;
              state_q      <= StResp;
            end
          end
        end
        StResp: begin
          if (resp_last_q) begin
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            resp_data_q  <= '0;
            resp_word_q  <= '0;
            ready_q      <= 1'b1;
            state_q      <= StIdle;
          end else begin
            resp_data_q <= rd_data;
            resp_word_q <= rd_word;
            resp_last_q <= (resp_word_q == 2'd2);
          end
        end
        StWrMem: begin
          if (bus.mem_req_ready) begin
            mreq_valid_q <= 1'b0;
            mreq_write_q <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_last_q  <= 1'b1;
            resp_data_q  <= '0;
            resp_word_q  <= addr_word(addr_q);
            state_q      <= StResp;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.l1_req_ready  = ready_q;
  assign bus.l2_resp_valid = resp_valid_q;
  assign bus.l2_resp_data  = resp_data_q;
  assign bus.l2_resp_word  = resp_word_q;
  assign bus.l2_resp_last  = resp_last_q;
  assign bus.mem_req_valid = mreq_valid_q;
  assign bus.mem_req_write = mreq_write_q;
  assign bus.mem_addr      = maddr_q;
  assign bus.mem_wdata     = mwdata_q;

endmodule

// File: tb/tb_l2_cache.sv
// Scoreboard bench for l2_cache: cache/memory reference model, random memory timing.
module tb_l2_cache;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2_cache_if bus ();

  l2_cache dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  word;
    logic        last;
    int          exp_cyc;
  } resp_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  resp_t resp_q[$];
  mreq_t mreq_q[$];

  // Reference model of cache contents and of main memory.
  bit          m_valid [1024];
  logic [17:0] m_tag   [1024];
  logic [31:0] m_data  [1024][4];
  logic [31:0] bmem    [int unsigned];

  int n_vec = 0;
  int n_err = 0;

  // Memory-responder controls.
  int  force_stall = -1;
  int  abort_after = -1;
  bit  fill_aborted = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int unsigned key;
    key = a >> 2;
    if (bmem.exists(key)) return bmem[key];
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic resp_monitor();
    resp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.l2_resp_valid) begin
        if (resp_q.size() == 0) begin
          check("unexpected_resp", {32'h0, bus.l2_resp_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = resp_q.pop_front();
          check("resp_data", {32'h0, bus.l2_resp_data}, {32'h0, e.data});
          check("resp_word", {62'h0, bus.l2_resp_word}, {62'h0, e.word});
          check("resp_last", {63'h0, bus.l2_resp_last}, {63'h0, e.last});
          if (e.exp_cyc >= 0) check("hit_latency", 64'(cyc), 64'(e.exp_cyc));
        end
      end
    end
  endtask

  task automatic mem_responder();
    int    stall_left = 0;
    int    fill_left = 0;
    int    beat = 0;
    bit    in_req = 0;
    mreq_t cur;
    mreq_t e;
    logic [31:0] fill_addr = '0;
    forever begin
      @(negedge clk);
      bus.mem_req_ready   = 1'b0;
      bus.mem_rdata_valid = 1'b0;
      bus.mem_rdata       = $urandom;
      if (rst) begin
        in_req = 0;
        fill_left = 0;
      end else if (fill_left > 0) begin
        if (abort_after >= 0 && beat == abort_after) begin
          fill_left = 0;
          fill_aborted = 1;
        end else if ($urandom_range(0, 3) != 0) begin
          bus.mem_rdata_valid = 1'b1;
          bus.mem_rdata       = mem_word(fill_addr + 32'(4 * beat));
          beat++;
          fill_left--;
        end
      end else if (bus.mem_req_valid) begin
        if (!in_req) begin
          in_req = 1;
          cur.write = bus.mem_req_write;
          cur.addr  = bus.mem_addr;
          cur.wdata = bus.mem_wdata;
          stall_left = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 2));
          force_stall = -1;
          if (mreq_q.size() == 0) begin
            check("unexpected_mem_req", {32'h0, cur.addr}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = mreq_q.pop_front();
            check("mem_req_write", {63'h0, cur.write}, {63'h0, e.write});
            check("mem_addr", {32'h0, cur.addr}, {32'h0, e.addr});
            if (e.write) check("mem_wdata", {32'h0, cur.wdata}, {32'h0, e.wdata});
          end
        end else begin
          check("mem_req_stable", {bus.mem_req_write, bus.mem_addr, bus.mem_wdata},
                {cur.write, cur.addr, cur.wdata});
        end
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          bus.mem_req_ready = 1'b1;
          in_req = 0;
          if (!cur.write) begin
            fill_left = 4;
            beat = 0;
            fill_addr = cur.addr;
          end
        end
      end else if (abort_after < 0 && $urandom_range(0, 7) == 0) begin
        bus.mem_rdata_valid = 1'b1;
      end
    end
  endtask

  // Issue one request, push its expected traffic, and wait for it to complete.
  task automatic do_req(input logic [31:0] addr, input logic write, input logic [31:0] wdata);
    int          t;
    int unsigned n;
    int          idx;
    logic [17:0] tag;
    logic [1:0]  w;
    logic [31:0] line;
    resp_t       r;
    mreq_t       m;
    idx  = int'(addr[13:4]);
    tag  = addr[31:14];
    w    = addr[3:2];
    line = {addr[31:4], 4'h0};
    t = 0;
    while (!bus.l1_req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", {63'h0, bus.l1_req_ready}, 64'h1);
    bus.l1_req_valid = 1'b1;
    bus.l1_req_addr  = addr;
    bus.l1_req_write = write;
    bus.l1_req_wdata = wdata;
    @(posedge clk);
    #1;
    n = cyc;
    if (write) begin
      m.write = 1'b1; m.addr = {addr[31:2], 2'b00}; m.wdata = wdata;
      mreq_q.push_back(m);
      bmem[addr >> 2] = wdata;
      if (m_valid[idx] && m_tag[idx] == tag) m_data[idx][w] = wdata;
      r.data = '0; r.word = w; r.last = 1'b1; r.exp_cyc = -1;
      resp_q.push_back(r);
    end else begin
      bit hit;
      hit = m_valid[idx] && m_tag[idx] == tag;
      if (!hit) begin
        m.write = 1'b0; m.addr = line; m.wdata = '0;
        mreq_q.push_back(m);
        for (int k = 0; k < 4; k++) m_data[idx][k] = mem_word(line + 32'(4 * k));
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
      end
      for (int k = 0; k < 4; k++) begin
        r.data = m_data[idx][k]; r.word = 2'(k); r.last = (k == 3);
        r.exp_cyc = hit ? int'(n) + 1 + k : -1;
        resp_q.push_back(r);
      end
    end
    @(negedge clk);
    bus.l1_req_valid = 1'b0;
    t = 0;
    // While busy, keep offering junk requests that must be ignored.
    while ((resp_q.size() != 0 || !bus.l1_req_ready) && t < 300) begin
      bus.l1_req_valid = !bus.l1_req_ready && ($urandom_range(0, 1) == 1);
      bus.l1_req_addr  = $urandom;
      bus.l1_req_write = 1'($urandom);
      @(negedge clk);
      t++;
    end
    bus.l1_req_valid = 1'b0;
    if (t >= 300) check("resp_timeout", 64'(resp_q.size()), 64'h0);
  endtask

  task automatic reset_mid_fill(input logic [31:0] addr);
    int    t;
    mreq_t m;
    t = 0;
    while (!bus.l1_req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    abort_after  = 2;
    fill_aborted = 0;
    bus.l1_req_valid = 1'b1;
    bus.l1_req_addr  = addr;
    bus.l1_req_write = 1'b0;
    @(posedge clk);
    #1;
    m.write = 1'b0; m.addr = {addr[31:4], 4'h0}; m.wdata = '0;
    mreq_q.push_back(m);
    @(negedge clk);
    bus.l1_req_valid = 1'b0;
    t = 0;
    while (!fill_aborted && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("partial_fill_reached", {63'h0, fill_aborted}, 64'h1);
    rst = 1'b1;
    #1;
    check("outputs_in_reset",
          {bus.l1_req_ready, bus.l2_resp_valid, bus.l2_resp_last, bus.l2_resp_word,
           bus.mem_req_valid, bus.mem_req_write, bus.l2_resp_data, bus.mem_addr[23:0]}, 64'h0);
    for (int i = 0; i < 1024; i++) m_valid[i] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    abort_after = -1;
    @(negedge clk);
    check("ready_after_reset", {63'h0, bus.l1_req_ready}, 64'h1);
    do_req(addr, 1'b0, '0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [17:0] tags [4];
    logic [9:0]  idxs [4];
    logic [31:0] a;
    tags[0] = 18'h0; tags[1] = 18'h1; tags[2] = 18'h5; tags[3] = 18'h9;
    idxs[0] = 10'h123; idxs[1] = 10'h000; idxs[2] = 10'h3FF; idxs[3] = 10'h045;
    rst = 1'b1;
    bus.l1_req_valid    = 1'b0;
    bus.l1_req_addr     = '0;
    bus.l1_req_write    = 1'b0;
    bus.l1_req_wdata    = '0;
    bus.mem_req_ready   = 1'b0;
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata       = '0;
    for (int k = 0; k < 4; k++) bmem[(32'h1230 >> 2) + k] = 32'hA0A0_0000 + k;
    for (int i = 0; i < 1024; i++) m_valid[i] = 1'b0;
    fork
      resp_monitor();
      mem_responder();
    join_none

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {bus.l1_req_ready, bus.l2_resp_valid, bus.l2_resp_last, bus.l2_resp_word,
           bus.mem_req_valid, bus.mem_req_write, bus.l2_resp_data, bus.mem_addr[23:0]}, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_out_of_reset", {63'h0, bus.l1_req_ready}, 64'h1);

    do_req(32'h0000_1230, 1'b0, '0);          // cold miss
    do_req(32'h0000_1238, 1'b0, '0);          // hit, latency checked
    do_req(32'h0000_5230, 1'b0, '0);          // conflict eviction
    do_req(32'h0000_1230, 1'b0, '0);          // misses again
    do_req(32'h0000_5230, 1'b0, '0);          // bring 0x5230 back
    do_req(32'h0000_5234, 1'b1, 32'hDEAD_BEEF); // write hit
    do_req(32'h0000_5230, 1'b0, '0);          // hit, word 1 updated
    do_req(32'h0009_0000, 1'b1, 32'h1234_5678); // write miss
    do_req(32'h0009_0000, 1'b0, '0);          // still a miss
    force_stall = 5;
    do_req(32'h0000_3450, 1'b0, '0);          // memory backpressure
    force_stall = 5;
    do_req(32'h0000_3454, 1'b1, 32'hCAFE_F00D); // write backpressure
    reset_mid_fill(32'h0000_7770);

    for (int i = 0; i < 150; i++) begin
      a = {tags[$urandom_range(0, 3)], idxs[$urandom_range(0, 3)], 4'($urandom)};
      do_req(a, ($urandom_range(0, 9) < 3), $urandom);
    end

    repeat (10) @(negedge clk);
    check("resp_queue_drained", 64'(resp_q.size()), 64'h0);
    check("mem_queue_drained", 64'(mreq_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
